// File: rtl/ita_softmax_sched_pkg.sv
// Shared types and constants for the softmax scheduler.
// The controller FSM states are enumerated here so that other blocks can decode them.
package ita_softmax_sched_pkg;

  typedef logic [15:0] counter_t;

  localparam int unsigned SoftFifoDepth = 4;
  localparam int unsigned SoftPipeLat   = 3;

  typedef enum logic [1:0] {
    SoftIdle,
    SoftAcc,
    SoftDrain,
    SoftStream
  } softmax_sched_state_e;

endpackage

// File: rtl/ita_softmax_sched.sv
// Softmax sequencer for one row block: accumulation grants with FIFO back-pressure,
// a drain wait for the divisions, then the normalisation stream.
//
// state      | meaning
// SoftIdle   | waiting for start_i
// SoftAcc    | granting accumulation beats, throttling last-tile beats on FIFO space
// SoftDrain  | waiting for the M-th division (softmax_done_i)
// SoftStream | granting normalisation stream beats
module ita_softmax_sched
  import ita_softmax_sched_pkg::*;
#(
  parameter int unsigned M         = 64,
  parameter int unsigned N         = 16,
  parameter int unsigned FifoDepth = SoftFifoDepth,
  parameter int unsigned PipeLat   = SoftPipeLat
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  counter_t                     tile_s_i,
  input  logic                         calc_req_i,
  output logic                         calc_en_o,
  input  logic                         fifo_full_i,
  input  logic [$clog2(FifoDepth)-1:0] fifo_usage_i,
  input  logic                         softmax_done_i,
  input  logic                         stream_req_i,
  output logic                         stream_en_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned Beats  = M * M / N;
  localparam int unsigned BeatW  = $clog2(Beats);
  localparam int unsigned OccW   = $clog2(FifoDepth) + 1;
  localparam logic [BeatW-1:0] LastBeat  = BeatW'(Beats - 1);
  localparam logic [BeatW-1:0] PushStart = BeatW'(Beats - M);
  localparam logic [OccW-1:0]  DepthOcc  = OccW'(FifoDepth);

  softmax_sched_state_e state_q, state_d;
  logic [BeatW-1:0]     beat_cnt_q;
  counter_t             tile_cnt_q, tile_s_q;
  logic [PipeLat-1:0]   inflight_q;

  logic            last_beat, last_tile, push_beat, calc_grant, stream_grant;
  logic [OccW-1:0] occ;

  function automatic logic [OccW-1:0] popcount(input logic [PipeLat-1:0] v);
    logic [OccW-1:0] c;
    c = '0;
    for (int i = 0; i < PipeLat; i++) c = c + OccW'(v[i]);
    return c;
  endfunction

  assign last_beat = (beat_cnt_q == LastBeat);
  assign last_tile = (tile_cnt_q == tile_s_q - counter_t'(1));
  assign push_beat = (state_q == SoftAcc) && last_tile && (beat_cnt_q >= PushStart);

  // Grants still in the datapath pipeline count as occupied; same-cycle pops are not credited.
  assign occ = (fifo_full_i ? DepthOcc : OccW'(fifo_usage_i)) + popcount(inflight_q);

  assign calc_grant   = (state_q == SoftAcc) && calc_req_i && (!push_beat || (occ < DepthOcc));
  assign stream_grant = (state_q == SoftStream) && stream_req_i;

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    unique case (state_q)
      SoftIdle:   if (start_i) state_d = SoftAcc;
      SoftAcc:    if (calc_grant && last_tile && last_beat) state_d = SoftDrain;
      SoftDrain:  if (softmax_done_i) state_d = SoftStream;
      SoftStream: begin
        if (stream_grant && last_tile && last_beat) begin
          done_o  = 1'b1;
          state_d = SoftIdle;
        end
      end
      default:    state_d = SoftIdle;
    endcase
  end

  assign calc_en_o   = calc_grant;
  assign stream_en_o = stream_grant;
  assign busy_o      = (state_q != SoftIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SoftIdle;
      beat_cnt_q <= '0;
      tile_cnt_q <= '0;
      tile_s_q   <= '0;
      inflight_q <= '0;
    end else if (clear_i) begin
      state_q    <= SoftIdle;
      beat_cnt_q <= '0;
      tile_cnt_q <= '0;
      tile_s_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= {inflight_q[PipeLat-2:0], calc_grant & push_beat};
      if ((state_q == SoftIdle) && start_i) begin
        tile_s_q   <= tile_s_i;
        beat_cnt_q <= '0;
        tile_cnt_q <= '0;
      end else if ((state_q == SoftDrain) && softmax_done_i) begin
        beat_cnt_q <= '0;
        tile_cnt_q <= '0;
      end else if (calc_grant || stream_grant) begin
        if (last_beat) begin
          beat_cnt_q <= '0;
          tile_cnt_q <= last_tile ? '0 : tile_cnt_q + counter_t'(1);
        end else begin
          beat_cnt_q <= beat_cnt_q + BeatW'(1);
        end
      end
    end
  end

endmodule
